clock_field_editor: RTL and testbench

//   Edits the time (hh:mm:ss) and date (yy/mm/dd) while the set-mode FSM sits in
//   set-time or set-date. On entry it loads a shadow copy of the running value.

---
 rtl/clock_field_editor.sv | 183 ++++++++++++++++++
 tb/tb_clock_field_editor.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_field_editor.sv
`timescale 1ns/1ps
// Shadow editor for hh:mm:ss and yy/mm/dd values while the set-mode FSM is in set-time or set-date.
// Field/increment edits take effect one clk later; write strobes are combinational from state and enables.
// No backpressure: the timekeeper and calendar must accept time_wr/date_wr on the strobe cycle.
module clock_field_editor #(
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_time_en,
    input  logic       set_date_en,
    input  logic       field_next,
    input  logic       inc_key,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic [6:0] cur_year,
    input  logic [3:0] cur_month,
    input  logic [4:0] cur_day,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic [6:0] set_year,
    output logic [3:0] set_month,
    output logic [4:0] set_day,
    output logic       time_wr,
    output logic       date_wr,
    output logic [1:0] edit_field
);

    typedef enum logic [1:0] {IDLE, EDIT_TIME, EDIT_DATE} state_t;

    state_t           state;
    logic             key_prev;
    logic             rep_armed;
    logic             rep_first;
    logic [CNT_W-1:0] rep_cnt;

    function automatic logic [4:0] days_in(input logic [3:0] m, input logic [6:0] y);
        case (m)
            4'd2:                          days_in = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:       days_in = 5'd30;
            default:                       days_in = 5'd31;
        endcase
    endfunction

    function automatic logic [4:0] clamp_day(input logic [4:0] d, input logic [4:0] dm);
        clamp_day = (d > dm) ? dm : d;
    endfunction

    logic       editing;
    logic       press;
    logic       rep_hit;
    logic       bump;
    logic [4:0] hour_inc;
    logic [5:0] min_inc;
    logic [5:0] sec_inc;
    logic [6:0] year_inc;
    logic [3:0] month_inc;
    logic [4:0] day_inc;

    assign time_wr = (state == EDIT_TIME) && !set_time_en;
    assign date_wr = (state == EDIT_DATE) && !set_date_en;
    assign editing = ((state == EDIT_TIME) && set_time_en) ||
                     ((state == EDIT_DATE) && set_date_en);

    // An exit cycle is not an editing cycle, so an increment coinciding with a strobe is dropped.
    assign press   = inc_key && !key_prev;
    assign rep_hit = rep_armed && inc_key &&
                     (rep_first ? (rep_cnt == CNT_W'(REPEAT_DELAY))
                                : (rep_cnt == CNT_W'(REPEAT_PERIOD)));
    assign bump    = editing && (press || rep_hit);

    assign hour_inc  = (set_hour  == 5'd23) ? 5'd0 : set_hour + 5'd1;
    assign min_inc   = (set_min   == 6'd59) ? 6'd0 : set_min + 6'd1;
    assign sec_inc   = (set_sec   == 6'd59) ? 6'd0 : set_sec + 6'd1;
    assign year_inc  = (set_year  == 7'd99) ? 7'd0 : set_year + 7'd1;
    assign month_inc = (set_month == 4'd12) ? 4'd1 : set_month + 4'd1;
    assign day_inc   = (set_day >= days_in(set_month, set_year)) ? 5'd1 : set_day + 5'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            set_hour   <= 5'd0;
            set_min    <= 6'd0;
            set_sec    <= 6'd0;
            set_year   <= 7'd0;
            set_month  <= 4'd1;
            set_day    <= 5'd1;
            edit_field <= 2'd0;
            key_prev   <= 1'b0;
            rep_armed  <= 1'b0;
            rep_first  <= 1'b0;
            rep_cnt    <= '0;
        end else begin
            key_prev <= inc_key;

            // rep_cnt counts cycles since the last increment of a held key.
            if (!editing || !inc_key) begin
                rep_armed <= 1'b0;
                rep_first <= 1'b0;
                rep_cnt   <= '0;
            end else if (press) begin
                rep_armed <= 1'b1;
                rep_first <= 1'b1;
                rep_cnt   <= CNT_W'(1);
            end else if (rep_hit) begin
                rep_first <= 1'b0;
                rep_cnt   <= CNT_W'(1);
            end else if (rep_armed) begin
                rep_cnt   <= rep_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (set_time_en) begin
                        state      <= EDIT_TIME;
                        set_hour   <= cur_hour;
                        set_min    <= cur_min;
                        set_sec    <= cur_sec;
                        edit_field <= 2'd0;
                    end else if (set_date_en) begin
                        state      <= EDIT_DATE;
                        set_year   <= cur_year;
                        set_month  <= cur_month;
                        set_day    <= cur_day;
                        edit_field <= 2'd0;
                    end
                end
                EDIT_TIME: begin
                    if (!set_time_en) begin
                        if (set_date_en) begin
                            state      <= EDIT_DATE;
                            set_year   <= cur_year;
                            set_month  <= cur_month;
                            set_day    <= cur_day;
                            edit_field <= 2'd0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        if (bump) begin
                            case (edit_field)
                                2'd0:    set_hour <= hour_inc;
                                2'd1:    set_min  <= min_inc;
                                2'd2:    set_sec  <= sec_inc;
                                default: ;
                            endcase
                        end
                        if (field_next)
                            edit_field <= (edit_field == 2'd2) ? 2'd0 : edit_field + 2'd1;
                    end
                end
                EDIT_DATE: begin
                    if (!set_date_en) begin
                        state <= IDLE;
                    end else begin
                        if (bump) begin
                            case (edit_field)
                                2'd0: begin
                                    set_year <= year_inc;
                                    set_day  <= clamp_day(set_day, days_in(set_month, year_inc));
                                end
                                2'd1: begin
                                    set_month <= month_inc;
                                    set_day   <= clamp_day(set_day, days_in(month_inc, set_year));
                                end
                                2'd2:    set_day <= day_inc;
                                default: ;
                            endcase
                        end
                        if (field_next)
                            edit_field <= (edit_field == 2'd2) ? 2'd0 : edit_field + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_field_editor.sv
`timescale 1ns/1ps
// Randomized and directed bench for clock_field_editor with a reference model and strobe scoreboard.
module tb_clock_field_editor;
    localparam int DELAY  = 500;
    localparam int PERIOD = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       set_time_en, set_date_en, field_next, inc_key;
    logic [4:0] cur_hour;
    logic [5:0] cur_min, cur_sec;
    logic [6:0] cur_year;
    logic [3:0] cur_month;
    logic [4:0] cur_day;
    logic [4:0] set_hour;
    logic [5:0] set_min, set_sec;
    logic [6:0] set_year;
    logic [3:0] set_month;
    logic [4:0] set_day;
    logic       time_wr, date_wr;
    logic [1:0] edit_field;

    always #5 clk = ~clk;

    clock_field_editor #(.REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .set_time_en(set_time_en), .set_date_en(set_date_en),
        .field_next(field_next), .inc_key(inc_key),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
        .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .set_year(set_year), .set_month(set_month), .set_day(set_day),
        .time_wr(time_wr), .date_wr(date_wr), .edit_field(edit_field)
    );

    typedef struct {
        int cyc;
        bit is_time;
        int a, b, c;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_no  = 0;

    // Reference model: mode 0 idle, 1 time, 2 date; held = cycles since press, -1 if none.
    int m_mode, m_field, m_kprev, m_held;
    int m_t[3];
    int m_d[3];

    function automatic int dmax(input int m, input int y);
        if (m == 2) return (y % 4 == 0) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc_no, act, want);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_field = 0; m_kprev = 0; m_held = -1;
        m_t = '{0, 0, 0};
        m_d = '{0, 1, 1};
    endtask

    task automatic model_bump();
        if (m_mode == 1) begin
            case (m_field)
                0: m_t[0] = (m_t[0] + 1) % 24;
                1: m_t[1] = (m_t[1] + 1) % 60;
                default: m_t[2] = (m_t[2] + 1) % 60;
            endcase
        end else begin
            case (m_field)
                0: begin
                    m_d[0] = (m_d[0] + 1) % 100;
                    m_d[2] = imin(m_d[2], dmax(m_d[1], m_d[0]));
                end
                1: begin
                    m_d[1] = m_d[1] % 12 + 1;
                    m_d[2] = imin(m_d[2], dmax(m_d[1], m_d[0]));
                end
                default: m_d[2] = (m_d[2] >= dmax(m_d[1], m_d[0])) ? 1 : m_d[2] + 1;
            endcase
        end
    endtask

    task automatic load_time();
        m_t[0] = int'(cur_hour); m_t[1] = int'(cur_min); m_t[2] = int'(cur_sec);
    endtask

    task automatic load_date();
        m_d[0] = int'(cur_year); m_d[1] = int'(cur_month); m_d[2] = int'(cur_day);
    endtask

    task automatic model_step();
        exp_t e;
        bit   editing, fire;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_mode == 1 && !set_time_en) begin
            e.cyc = cyc_no; e.is_time = 1'b1; e.a = m_t[0]; e.b = m_t[1]; e.c = m_t[2];
            q.push_back(e);
        end
        if (m_mode == 2 && !set_date_en) begin
            e.cyc = cyc_no; e.is_time = 1'b0; e.a = m_d[0]; e.b = m_d[1]; e.c = m_d[2];
            q.push_back(e);
        end
        editing = (m_mode == 1 && set_time_en) || (m_mode == 2 && set_date_en);
        if (editing) begin
            if (!inc_key)      m_held = -1;
            else if (!m_kprev) m_held = 0;
            else if (m_held >= 0) m_held++;
            fire = inc_key && m_held >= 0 &&
                   (m_held == 0 || (m_held >= DELAY && (m_held - DELAY) % PERIOD == 0));
            if (fire) model_bump();
            if (field_next) m_field = (m_field + 1) % 3;
        end else begin
            m_held = -1;
            if (m_mode == 0) begin
                if (set_time_en)      begin m_mode = 1; load_time(); m_field = 0; end
                else if (set_date_en) begin m_mode = 2; load_date(); m_field = 0; end
            end else if (m_mode == 1) begin
                if (set_date_en) begin m_mode = 2; load_date(); m_field = 0; end
                else m_mode = 0;
            end else begin
                m_mode = 0;
            end
        end
        m_kprev = int'(inc_key);
    endtask

    function automatic logic [63:0] model_pack();
        return {29'd0, 5'(m_t[0]), 6'(m_t[1]), 6'(m_t[2]),
                7'(m_d[0]), 4'(m_d[1]), 5'(m_d[2]), 2'(m_field)};
    endfunction

    // Inputs are driven at posedge+2; the model steps, then registered outputs are compared at posedge+1.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("shadow", {29'd0, set_hour, set_min, set_sec, set_year, set_month, set_day, edit_field},
              model_pack());
        cyc_no++;
        #1;
    endtask

    task automatic rand_cur();
        cur_hour  = 5'($urandom_range(23));
        cur_min   = 6'($urandom_range(59));
        cur_sec   = 6'($urandom_range(59));
        cur_year  = 7'($urandom_range(99));
        cur_month = 4'($urandom_range(12, 1));
        cur_day   = 5'($urandom_range(31, 1));
    endtask

    task automatic press_key();
        inc_key = 1'b1; cycle();
        inc_key = 1'b0; cycle();
    endtask

    // Strobe monitor: pops the expected write whenever the DUT presents one.
    always @(negedge clk) begin
        exp_t e;
        int   aa, ab, ac;
        if (time_wr || date_wr) begin
            n_tests++;
            aa = time_wr ? int'(set_hour) : int'(set_year);
            ab = time_wr ? int'(set_min)  : int'(set_month);
            ac = time_wr ? int'(set_sec)  : int'(set_day);
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL strobe_unexpected at cycle %0d: time_wr=%0b date_wr=%0b, expected none",
                         cyc_no, time_wr, date_wr);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc_no || e.is_time != time_wr || (time_wr && date_wr) ||
                    e.a != aa || e.b != ab || e.c != ac) begin
                    n_fail++;
                    $display("FAIL strobe at cycle %0d: got t=%0b d=%0b %0d/%0d/%0d, expected cycle %0d t=%0b %0d/%0d/%0d",
                             cyc_no, time_wr, date_wr, aa, ab, ac, e.cyc, e.is_time, e.a, e.b, e.c);
                end
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc_no) begin
            e = q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL strobe_missing at cycle %0d: got no strobe, expected t=%0b %0d/%0d/%0d",
                     cyc_no, e.is_time, e.a, e.b, e.c);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; set_time_en = 1'b0; set_date_en = 1'b0;
        field_next = 1'b0; inc_key = 1'b0;
        rand_cur();
        model_reset();
        #2;
        repeat (3) cycle();
        rst_n = 1'b1;

        // Idle: keys and field_next are ignored, no strobes.
        for (int i = 0; i < 100; i++) begin
            rand_cur();
            inc_key = 1'($urandom_range(1));
            field_next = 1'($urandom_range(1));
            cycle();
        end
        check("idle_month", 64'(set_month), 64'd1);
        check("idle_day", 64'(set_day), 64'd1);
        check("idle_hour", 64'(set_hour), 64'd0);
        inc_key = 1'b0; field_next = 1'b0; cycle();

        // Three presses on hour from 23:59:58, then write back.
        cur_hour = 5'd23; cur_min = 6'd58 + 6'd1; cur_sec = 6'd58;
        set_time_en = 1'b1; cycle(); cycle();
        repeat (3) press_key();
        set_time_en = 1'b0; cycle();
        check("t2_hour", 64'(set_hour), 64'd2);
        check("t2_min", 64'(set_min), 64'd59);
        cycle(); cycle();

        // Auto-repeat on minutes: 58 -> 59,0,1,2.
        cur_min = 6'd58;
        set_time_en = 1'b1; cycle();
        field_next = 1'b1; cycle(); field_next = 1'b0;
        inc_key = 1'b1;
        repeat (DELAY + 2 * PERIOD + 1) cycle();
        inc_key = 1'b0; cycle();
        check("t3_min", 64'(set_min), 64'd2);
        set_time_en = 1'b0; cycle(); cycle();

        // Month increment clamps the day; leap and non-leap Februaries.
        cur_year = 7'd24; cur_month = 4'd1; cur_day = 5'd31;
        set_date_en = 1'b1; cycle();
        field_next = 1'b1; cycle(); field_next = 1'b0;
        press_key();
        check("t4_month", 64'(set_month), 64'd2);
        check("t4_day_leap", 64'(set_day), 64'd29);
        set_date_en = 1'b0; cycle(); cycle();
        cur_year = 7'd23;
        set_date_en = 1'b1; cycle();
        field_next = 1'b1; cycle(); field_next = 1'b0;
        press_key();
        check("t4_day_noleap", 64'(set_day), 64'd28);
        field_next = 1'b1; cycle(); field_next = 1'b0;
        press_key();
        check("t4_day_wrap", 64'(set_day), 64'd1);
        set_date_en = 1'b0; cycle(); cycle();

        // Direct hand-over from set-time to set-date.
        cur_year = 7'd50; cur_month = 4'd7; cur_day = 5'd15;
        set_time_en = 1'b1; cycle();
        field_next = 1'b1; cycle(); field_next = 1'b0;
        set_time_en = 1'b0; set_date_en = 1'b1; cycle();
        check("t5_field", 64'(edit_field), 64'd0);
        check("t5_year", 64'(set_year), 64'd50);
        check("t5_day", 64'(set_day), 64'd15);
        set_date_en = 1'b0; cycle(); cycle();

        // Reset mid-edit, then a key held across entry.
        cur_hour = 5'd7;
        set_time_en = 1'b1; cycle();
        press_key();
        rst_n = 1'b0; cycle();
        check("t6_rst_hour", 64'(set_hour), 64'd0);
        check("t6_rst_month", 64'(set_month), 64'd1);
        rst_n = 1'b1; set_time_en = 1'b0; inc_key = 1'b1; cycle();
        set_time_en = 1'b1;
        repeat (5) cycle();
        check("t6_held_hour", 64'(set_hour), 64'd7);
        inc_key = 1'b0; set_time_en = 1'b0; cycle(); cycle();

        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            rand_cur();
            if ($urandom_range(29) == 0) set_time_en = ~set_time_en;
            if ($urandom_range(29) == 0) set_date_en = ~set_date_en;
            if ($urandom_range(3) == 0) inc_key = ~inc_key;
            field_next = ($urandom_range(9) == 0);
            if ($urandom_range(999) == 0) rst_n = 1'b0; else rst_n = 1'b1;
            cycle();
        end
        rst_n = 1'b1; set_time_en = 1'b0; set_date_en = 1'b0;
        inc_key = 1'b0; field_next = 1'b0;
        repeat (4) cycle();
        check("queue_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
